// File: rtl/lfsr4_checker_pkg.sv
// Shared definitions for the x^4+x^3+1 LFSR stream checker.
// Holds the checker state encoding, the feedback tap positions and the default parameters.
package lfsr4_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

  localparam int DEF_LOCK_THRESH = 8;
  localparam int DEF_LOSS_THRESH = 3;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/lfsr4_checker_if.sv
// Stream-side bundle of the LFSR checker.
// The master drives the received bits and the error clear; the slave returns the lock and error status.
interface lfsr4_checker_if
  import lfsr4_checker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             din;
  logic             din_valid;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output din, din_valid, err_clr,
    input  locked, err_pulse, err_cnt
  );

  modport slave (
    input  din, din_valid, err_clr,
    output locked, err_pulse, err_cnt
  );

endinterface

// File: rtl/lfsr4_sat_counter.sv
// Saturating error counter: counts up on inc, sticks at all-ones.
// A clear in the same cycle as an increment leaves the count at one, so that error is not lost.
module lfsr4_sat_counter
  import lfsr4_checker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/lfsr4_checker.sv
// Self-synchronising checker for an x^4+x^3+1 LFSR bit stream.
// Seeds from the received bits, hunts for a run of matches, then counts and flags bit errors while locked.
module lfsr4_checker
  import lfsr4_checker_pkg::*;
#(
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  lfsr4_checker_if.slave  bus
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  chk_state_e         state_d, state_q;
  logic [3:0]         sr_d, sr_q;
  logic [1:0]         seed_cnt_d, seed_cnt_q;
  logic [MATCH_W-1:0] match_run_d, match_run_q;
  logic [MISS_W-1:0]  miss_run_d, miss_run_q;
  logic               locked_d, locked_q;
  logic               err_pulse_d, err_pulse_q;
  logic               err_inc;
  logic               predicted;
  logic               mismatch;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic [CNT_W-1:0]   err_cnt;

  // An all-zero history is the LFSR lock-up state and cannot predict anything, so it forces a reseed.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    seed_cnt_d  = seed_cnt_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_inc     = 1'b0;
    predicted   = sr_q[TAP_HI] ^ sr_q[TAP_LO];
    mismatch    = bus.din != predicted;
    match_inc   = match_run_q + MATCH_W'(1);
    miss_inc    = miss_run_q + MISS_W'(1);

    if (bus.din_valid) begin
      sr_d = {sr_q[2:0], bus.din};
      unique case (state_q)
        ST_SEED: begin
          seed_cnt_d = seed_cnt_q + 2'd1;
          if (seed_cnt_q == 2'd3) begin
            state_d     = ST_HUNT;
            match_run_d = '0;
          end
        end
        ST_HUNT: begin
          if (sr_q == 4'b0000) begin
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_run_d = '0;
            miss_run_d  = '0;
          end else if (mismatch) begin
            match_run_d = '0;
          end else if (match_inc == MATCH_W'(LOCK_THRESH)) begin
            state_d     = ST_LOCKED;
            match_run_d = '0;
            miss_run_d  = '0;
          end else begin
            match_run_d = match_inc;
          end
        end
        ST_LOCKED: begin
          if (sr_q == 4'b0000) begin
            state_d     = ST_SEED;
            seed_cnt_d  = '0;
            match_run_d = '0;
            miss_run_d  = '0;
          end else if (mismatch) begin
            err_inc = 1'b1;
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              state_d     = ST_SEED;
              seed_cnt_d  = '0;
              match_run_d = '0;
              miss_run_d  = '0;
            end else begin
              miss_run_d = miss_inc;
            end
          end else begin
            miss_run_d = '0;
          end
        end
        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
        end
      endcase
    end

    locked_d    = (state_d == ST_LOCKED);
    err_pulse_d = err_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      sr_q        <= 4'b0000;
      seed_cnt_q  <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  lfsr4_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (bus.err_clr),
    .count (err_cnt)
  );

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_lfsr4_checker.sv
// Directed bench for lfsr4_checker: a vector table for lock-up and single-error behaviour,
// followed by hand-written sequences for lock loss, reset, long runs, invalid streams and saturation.
module tb_lfsr4_checker;

  typedef struct {
    logic din;
    logic valid;
    logic clr;
    logic exp_locked;
    logic exp_pulse;
    int   exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   pos;
  logic stream_ref [15];
  vec_t vecs [$];

  lfsr4_checker_if #(.CNT_W(8)) bus ();

  lfsr4_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic d, input logic v, input logic c);
    bus.din       = d;
    bus.din_valid = v;
    bus.err_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int l, input int p, input int c);
    checkOutput({name, " locked"}, int'(bus.locked), l);
    checkOutput({name, " err_pulse"}, int'(bus.err_pulse), p);
    checkOutput({name, " err_cnt"}, int'(bus.err_cnt), c);
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(stream_ref[pos % 15], 1'b1, 1'b0);
      pos++;
    end
  endtask

  task automatic send_flip();
    applyStimulus(~stream_ref[pos % 15], 1'b1, 1'b0);
    pos++;
  endtask

  // Reset is held with valid and clear asserted to show it overrides both.
  task automatic do_reset(input string name);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.err_clr   = 1'b0;
    pos = 0;
    check_all(name, 0, 0, 0);
  endtask

  initial begin
    int any_bad;
    n_checks = 0;
    n_fail   = 0;
    pos      = 0;
    rst      = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.err_clr   = 1'b0;
    stream_ref = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Lock on the 12th valid bit, then a stall, one flipped bit and error clears.
    for (int i = 0; i < 12; i++)
      vecs.push_back('{stream_ref[i], 1'b1, 1'b0, (i == 11), 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3});

    do_reset("reset");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din, vecs[i].valid, vecs[i].clr);
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_locked),
                int'(vecs[i].exp_pulse), vecs[i].exp_cnt);
    end

    // Three consecutive flipped bits drop lock; relock after 4 seed + 8 hunt bits.
    do_reset("reset2");
    send_clean(15);
    check_all("pre_burst", 1, 0, 0);
    send_flip();
    check_all("burst1", 1, 1, 1);
    send_flip();
    check_all("burst2", 1, 1, 2);
    send_flip();
    check_all("burst3", 0, 1, 3);
    send_clean(11);
    check_all("relock_11", 0, 0, 3);
    send_clean(1);
    check_all("relock_12", 1, 0, 3);

    // Reset while locked with errors pending clears everything on that edge.
    do_reset("reset_locked");
    send_clean(11);
    check_all("resync_11", 0, 0, 0);
    send_clean(1);
    check_all("resync_12", 1, 0, 0);

    any_bad = 0;
    for (int i = 0; i < 100; i++) begin
      send_clean(1);
      if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd0) any_bad++;
    end
    checkOutput("clean100 bad_cycles", any_bad, 0);
    check_all("clean100_end", 1, 0, 0);

    // All-zero input never locks and never counts errors.
    do_reset("reset_zero");
    any_bad = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.locked !== 1'b0 || bus.err_cnt !== 8'd0) any_bad++;
    end
    checkOutput("zeros bad_cycles", any_bad, 0);

    // Gaps between valid bits are ignored: lock still on the 12th valid bit.
    do_reset("reset_gap");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("gap%0d idle locked", i), int'(bus.locked), 0);
      send_clean(1);
      checkOutput($sformatf("gap%0d locked", i), int'(bus.locked), (i == 11) ? 1 : 0);
    end
    checkOutput("gap err_cnt", int'(bus.err_cnt), 0);

    // 85 single flips give 255 errors; one more must saturate; clear with an error gives 1.
    do_reset("reset_sat");
    send_clean(15);
    for (int k = 0; k < 85; k++) begin
      send_flip();
      send_clean(14);
    end
    check_all("sat_255", 1, 0, 255);
    send_flip();
    checkOutput("sat_hold err_cnt", int'(bus.err_cnt), 255);
    checkOutput("sat_hold locked", int'(bus.locked), 1);
    send_clean(2);
    applyStimulus(stream_ref[pos % 15], 1'b1, 1'b1);
    pos++;
    check_all("clr_with_err", 1, 1, 1);
    send_clean(1);
    check_all("after_clr_err", 1, 1, 2);
    applyStimulus(stream_ref[pos % 15], 1'b1, 1'b1);
    pos++;
    check_all("clr_alone", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr4_checker.md
LFSR4_CHECKER -- requirements
Module: lfsr4_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 8, consecutive matches required to assert lock.
REQ-002 Parameter LOSS_THRESH, default 3, consecutive mismatches while locked that drop lock.
REQ-003 Parameter CNT_W, default 8, width of error counter.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  1  received serial bit of x^4+x^3+1 LFSR stream (generator feedback bit r[3]^r[2], shifted in at LSB).
REQ-007 din_valid  input  1  din qualifier; no state change when low.
REQ-008 err_clr  input  1  synchronous clear of err_cnt.
REQ-009 locked  output  1  registered; checker synchronised to stream.
REQ-010 err_pulse  output  1  registered one-cycle strobe per mismatch counted.
REQ-011 err_cnt  output  CNT_W  saturating count of mismatches while locked.

Function
REQ-012 Internal 4-bit register sr; each valid bit: predicted = sr[3]^sr[2], then sr <= {sr[2:0], din} (received bit always shifted in, self-synchronising).
REQ-013 States: SEED, HUNT, LOCKED.
REQ-014 SEED: 2-bit seed counter counts valid bits; no comparisons; after 4th valid bit go to HUNT with match_run = 0.
REQ-015 HUNT/LOCKED compare din against predicted on every valid bit, before the shift.
REQ-016 If sr == 4'b0000 at a valid bit in HUNT or LOCKED: treat as invalid, go to SEED, seed counter 0, deassert locked, no error counted.
REQ-017 HUNT: match increments match_run; mismatch resets match_run to 0, no error counted; match_run reaching LOCK_THRESH -> LOCKED, locked = 1 from that same edge.
REQ-018 LOCKED: mismatch -> err_pulse = 1 next cycle, err_cnt + 1 (saturate at 2^CNT_W-1), miss_run + 1; match -> miss_run = 0.
REQ-019 LOCKED: miss_run reaching LOSS_THRESH -> SEED, locked = 0 on that edge (that mismatch still counted).
REQ-020 err_pulse low in every cycle without a counted mismatch, including din_valid low cycles.
REQ-021 err_clr and counted mismatch same cycle -> err_cnt = 1; err_clr alone -> 0.
REQ-022 err_clr has no effect on state, sr, locked or run counters.

Reset
REQ-023 rst = 1: state SEED, sr = 4'b0000, seed counter, match_run, miss_run = 0, locked = 0, err_pulse = 0, err_cnt = 0; overrides din_valid and err_clr.
REQ-024 Reset mid-lock: locked = 0 on the reset edge; resynchronisation needs full SEED + LOCK_THRESH sequence.

Structure
REQ-025 Shared package holds state enum (SEED/HUNT/LOCKED), polynomial tap indices (3,2), default LOCK_THRESH/LOSS_THRESH/CNT_W.
REQ-026 One sub-module natural: lfsr4_sat_counter (CNT_W saturating counter, inc/clr inputs, REQ-021 priority).

Verification
Reference stream from generator seed 1111 (period 15): 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeating.
REQ-027 Clean stream, din_valid constant 1 -> locked rises on the edge of the 12th valid bit; err_cnt stays 0 over 100 bits.
REQ-028 Locked, invert one bit at index t -> mismatches at t, t+3, t+4; err_pulse 3 times; err_cnt = 3; locked stays 1.
REQ-029 Locked, invert three consecutive bits -> third mismatch drops locked; err_cnt = 3; relock after 4 + 8 clean bits.
REQ-030 Constant-zero din -> never locked, err_cnt = 0; din_valid toggled 50% on clean stream -> lock after 12 valid bits, no extra errors.
REQ-031 err_cnt at 255 plus mismatch -> stays 255; err_clr coincident with mismatch -> 1.
REQ-032 rst asserted while locked -> next cycle locked = 0, err_cnt = 0, err_pulse = 0.
